// File: rtl/regfile_sb_pkg.sv
// Shared sizing helpers and port-slice types for the scoreboarded register file.
package regfile_sb_pkg;

  localparam int MAX_NRPORTS = 4;
  localparam int MAX_NWPORTS = 2;
  localparam int MAX_AW      = 16;
  localparam int MAX_DW      = 64;

  function automatic int addr_width(input int nregs);
    return (nregs <= 1) ? 1 : $clog2(nregs);
  endfunction

  // Addresses are zero-extended to MAX_AW so read and write slices compare directly.
  typedef struct packed {
    logic              en;
    logic [MAX_AW-1:0] addr;
  } rport_t;

  typedef struct packed {
    logic              en;
    logic [MAX_AW-1:0] addr;
  } wport_t;

  typedef logic [MAX_DW-1:0] word_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register pending bits: set on accepted allocation, cleared by writeback or flush.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int  NUMREGS  = 32,
  parameter int  ZERO_REG = 1,
  localparam int AW       = addr_width(NUMREGS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUMREGS-1:0] clr_i,
  input  logic               alloc_valid_i,
  input  logic [AW-1:0]      alloc_addr_i,
  input  logic               flush_i,
  output logic               alloc_ready_o,
  output logic [NUMREGS-1:0] pending_o
);

  logic [NUMREGS-1:0] pend_q;
  logic [NUMREGS-1:0] set_vec;
  logic               alloc_zero;
  logic               ready;

  assign alloc_zero = (ZERO_REG != 0) && (alloc_addr_i == '0);

  // A same-cycle writeback frees the register, so re-allocation is allowed.
  always_comb begin
    ready   = 1'b0;
    set_vec = '0;
    if (!flush_i) begin
      ready = alloc_zero || !pend_q[alloc_addr_i] || clr_i[alloc_addr_i];
      if (alloc_valid_i && ready && !alloc_zero) begin
        set_vec[alloc_addr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
    end else if (flush_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= (pend_q & ~clr_i) | set_vec;
    end
  end

  assign alloc_ready_o = ready;
  assign pending_o     = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-to-read bypass and issue scoreboard.
// Optional stored parity per register when REGFILE_SB_PARITY_EN is defined.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int  NUMREGS   = 32,
  parameter int  DATAWIDTH = 32,
  parameter int  NRPORTS   = 2,
  parameter int  NWPORTS   = 1,
  parameter int  ZERO_REG  = 1,
  localparam int AW        = addr_width(NUMREGS)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NRPORTS-1:0]             re_i,
  input  logic [NRPORTS*AW-1:0]          raddr_i,
  output logic [NRPORTS*DATAWIDTH-1:0]   rdata_o,
  output logic [NRPORTS-1:0]             rbusy_o,
  input  logic [NWPORTS-1:0]             we_i,
  input  logic [NWPORTS*AW-1:0]          waddr_i,
  input  logic [NWPORTS*DATAWIDTH-1:0]   wdata_i,
  input  logic                           alloc_valid_i,
  input  logic [AW-1:0]                  alloc_addr_i,
  output logic                           alloc_ready_o,
  input  logic                           flush_i,
  output logic [NUMREGS-1:0]             pending_o
`ifdef REGFILE_SB_PARITY_EN
  ,
  output logic [NRPORTS-1:0]             perr_o,
  input  logic                           perr_inject_i
`endif
);

  rport_t               rp [NRPORTS];
  wport_t               wp [NWPORTS];
  logic [DATAWIDTH-1:0] mem [NUMREGS];
  logic [NUMREGS-1:0]   clr_vec;
  logic [NRPORTS-1:0]   byp_hit;
  logic [DATAWIDTH-1:0] byp_data [NRPORTS];
  logic [NRPORTS-1:0]   rd_zero;

  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      rp[p].en   = re_i[p];
      rp[p].addr = MAX_AW'(raddr_i[p*AW +: AW]);
    end
    for (int i = 0; i < NWPORTS; i++) begin
      wp[i].en   = we_i[i];
      wp[i].addr = MAX_AW'(waddr_i[i*AW +: AW]);
    end
  end

  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NWPORTS; i++) begin
      if (wp[i].en) clr_vec[wp[i].addr[AW-1:0]] = 1'b1;
    end
  end

  // Later write ports override earlier ones, so the highest index wins the bypass.
  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      byp_hit[p]  = 1'b0;
      byp_data[p] = '0;
      for (int i = 0; i < NWPORTS; i++) begin
        if (wp[i].en && (wp[i].addr == rp[p].addr)) begin
          byp_hit[p]  = 1'b1;
          byp_data[p] = wdata_i[i*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      rd_zero[p] = (ZERO_REG != 0) && (rp[p].addr == '0);
      if (!rp[p].en || rd_zero[p]) begin
        rdata_o[p*DATAWIDTH +: DATAWIDTH] = '0;
      end else if (byp_hit[p]) begin
        rdata_o[p*DATAWIDTH +: DATAWIDTH] = byp_data[p];
      end else begin
        rdata_o[p*DATAWIDTH +: DATAWIDTH] = mem[rp[p].addr[AW-1:0]];
      end
      rbusy_o[p] = rp[p].en && pending_o[rp[p].addr[AW-1:0]] && !byp_hit[p];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NUMREGS; r++) mem[r] <= '0;
    end else begin
      for (int i = 0; i < NWPORTS; i++) begin
        if (wp[i].en && !((ZERO_REG != 0) && (wp[i].addr == '0))) begin
          mem[wp[i].addr[AW-1:0]] <= wdata_i[i*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

`ifdef REGFILE_SB_PARITY_EN
  logic [NUMREGS-1:0] par_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      par_q <= '0;
    end else begin
      for (int i = 0; i < NWPORTS; i++) begin
        if (wp[i].en && !((ZERO_REG != 0) && (wp[i].addr == '0))) begin
          par_q[wp[i].addr[AW-1:0]] <= (^wdata_i[i*DATAWIDTH +: DATAWIDTH]) ^ perr_inject_i;
        end
      end
    end
  end

  // Only stored data can be corrupt; bypassed data comes straight from writeback.
  always_comb begin
    for (int p = 0; p < NRPORTS; p++) begin
      perr_o[p] = rp[p].en && !byp_hit[p] && (rp[p].addr != '0) &&
                  ((^mem[rp[p].addr[AW-1:0]]) != par_q[rp[p].addr[AW-1:0]]);
    end
  end
`endif

  regfile_sb_scoreboard #(
    .NUMREGS  (NUMREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clr_i         (clr_vec),
    .alloc_valid_i (alloc_valid_i),
    .alloc_addr_i  (alloc_addr_i),
    .flush_i       (flush_i),
    .alloc_ready_o (alloc_ready_o),
    .pending_o     (pending_o)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with two read and two write ports.
module tb_regfile_sb;

  localparam int NR = 2;
  localparam int NW = 2;
  localparam int AW = 5;
  localparam int DW = 32;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic [NR-1:0]  re;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]  rbusy;
  logic [NW-1:0]  we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic           alloc_valid;
  logic [AW-1:0]  alloc_addr;
  logic           alloc_ready;
  logic           flush;
  logic [31:0]    pending;
`ifdef REGFILE_SB_PARITY_EN
  logic [NR-1:0]  perr;
  logic           perr_inject;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_sb #(
    .NUMREGS(32), .DATAWIDTH(DW), .NRPORTS(NR), .NWPORTS(NW), .ZERO_REG(1)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .re_i          (re),
    .raddr_i       (raddr),
    .rdata_o       (rdata),
    .rbusy_o       (rbusy),
    .we_i          (we),
    .waddr_i       (waddr),
    .wdata_i       (wdata),
    .alloc_valid_i (alloc_valid),
    .alloc_addr_i  (alloc_addr),
    .alloc_ready_o (alloc_ready),
    .flush_i       (flush),
    .pending_o     (pending)
`ifdef REGFILE_SB_PARITY_EN
    ,
    .perr_o        (perr),
    .perr_inject_i (perr_inject)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a);
    re[p] = 1'b1;
    raddr[p*AW +: AW] = a;
  endtask

  task automatic wr(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we[i] = 1'b1;
    waddr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
  endtask

  task automatic idle();
    re = '0; raddr = '0; we = '0; waddr = '0; wdata = '0;
    alloc_valid = 1'b0; alloc_addr = '0; flush = 1'b0;
`ifdef REGFILE_SB_PARITY_EN
    perr_inject = 1'b0;
`endif
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    #3;
    chk("rst_pending", 64'(pending), 64'h0);
    chk("rst_ready", 64'(alloc_ready), 64'h1);
    chk("rst_rdata_re0", 64'(rdata), 64'h0);
    chk("rst_rbusy_re0", 64'(rbusy), 64'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    for (int a = 0; a < 32; a++) begin
      rd(0, AW'(a));
      rd(1, AW'(31 - a));
      #1;
      chk("rst_read_data", 64'(rdata), 64'h0);
      chk("rst_read_busy", 64'(rbusy), 64'h0);
    end
    idle();

    // Bypass then stored value for r5
    tick();
    wr(0, 5'd5, 32'hDEADBEEF);
    rd(0, 5'd5);
    #1;
    chk("r5_bypass", 64'(rdata[31:0]), 64'hDEADBEEF);
    tick();
    we = '0;
    #1;
    chk("r5_stored", 64'(rdata[31:0]), 64'hDEADBEEF);

    wr(0, 5'd0, 32'h1234);
    rd(1, 5'd0);
    #1;
    chk("r0_same_cycle", 64'(rdata[63:32]), 64'h0);
    tick();
    we = '0;
    rd(0, 5'd0);
    #1;
    chk("r0_stored", 64'(rdata[31:0]), 64'h0);
    idle();

    // Both ports to r7: port 1 wins
    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    rd(1, 5'd7);
    #1;
    chk("r7_bypass_prio", 64'(rdata[63:32]), 64'h22);
    tick();
    we = '0;
    rd(0, 5'd7);
    #1;
    chk("r7_stored_prio", 64'(rdata[31:0]), 64'h22);
    chk("r7_stored_p1", 64'(rdata[63:32]), 64'h22);
    idle();

    // Allocation of r3
    alloc_valid = 1'b1; alloc_addr = 5'd3;
    #1;
    chk("alloc3_ready", 64'(alloc_ready), 64'h1);
    tick();
    alloc_valid = 1'b0;
    rd(0, 5'd3);
    #1;
    chk("alloc3_pending", 64'(pending), 64'h8);
    chk("alloc3_rbusy", 64'(rbusy), 64'h1);
    alloc_valid = 1'b1;
    #1;
    chk("alloc3_again_ready", 64'(alloc_ready), 64'h0);
    tick();
    wr(0, 5'd3, 32'h55);
    #1;
    chk("alloc3_wr_ready", 64'(alloc_ready), 64'h1);
    chk("r3_wr_bypass", 64'(rdata[31:0]), 64'h55);
    chk("r3_wr_rbusy", 64'(rbusy), 64'h0);
    tick();
    we = '0; alloc_valid = 1'b0;
    #1;
    chk("r3_set_beats_clr", 64'(pending), 64'h8);
    chk("r3_stored", 64'(rdata[31:0]), 64'h55);
    chk("r3_busy_again", 64'(rbusy), 64'h1);
    idle();

    // Allocation of r0 never sets a bit
    alloc_valid = 1'b1; alloc_addr = 5'd0;
    #1;
    chk("alloc0_ready", 64'(alloc_ready), 64'h1);
    tick();
    alloc_valid = 1'b0;
    #1;
    chk("alloc0_pending", 64'(pending), 64'h8);

    // Fill then flush with concurrent alloc
    alloc_valid = 1'b1;
    alloc_addr = 5'd1; tick();
    alloc_addr = 5'd2; tick();
    alloc_addr = 5'd4; tick();
    alloc_valid = 1'b0;
    #1;
    chk("multi_pending", 64'(pending), 64'h1E);
    alloc_valid = 1'b1; alloc_addr = 5'd6; flush = 1'b1;
    #1;
    chk("flush_ready", 64'(alloc_ready), 64'h0);
    tick();
    idle();
    #1;
    chk("flush_pending", 64'(pending), 64'h0);
    chk("flush_ready_after", 64'(alloc_ready), 64'h1);

    // Asynchronous reset mid-sequence
    wr(1, 5'd9, 32'hA5);
    tick();
    we = '0;
    alloc_valid = 1'b1; alloc_addr = 5'd9;
    tick();
    alloc_valid = 1'b0;
    rd(1, 5'd9);
    #1;
    chk("r9_pending", 64'(pending), 64'h200);
    chk("r9_data", 64'(rdata[63:32]), 64'hA5);
    chk("r9_busy", 64'(rbusy), 64'h2);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_pending", 64'(pending), 64'h0);
    chk("async_rst_r9", 64'(rdata[63:32]), 64'h0);
    chk("async_rst_busy", 64'(rbusy), 64'h0);
    rst_ni = 1'b1;
    idle();

`ifdef REGFILE_SB_PARITY_EN
    tick();
    wr(0, 5'd8, 32'h3);
    perr_inject = 1'b1;
    rd(1, 5'd8);
    #1;
    chk("perr_bypass", 64'(perr), 64'h0);
    tick();
    we = '0; perr_inject = 1'b0;
    rd(0, 5'd8);
    #1;
    chk("perr_injected", 64'(perr), 64'h3);
    wr(0, 5'd10, 32'h7);
    tick();
    idle();
    rd(0, 5'd10);
    #1;
    chk("perr_clean", 64'(perr), 64'h0);
    idle();
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
